time_uart_tx: RTL

Serialises the current time of day (hours 0-23, minutes 0-59, from the time counter) as the 7-byte ASCII message "HH:MM\r\n" on a UART TX line, 8N1, LSB first.
- It is the transmit direction of the UART link that already sets the clock; the host uses it to read back the time.
- Transmission starts on an explicit request, or automatically on every minute change when auto mode is enabled.

---
 rtl/time_uart_pkg.sv | 51 +++++
 rtl/time_uart_tx_if.sv | 13 +
 rtl/uart_tx_byte.sv | 90 +++++++++
 rtl/time_uart_tx.sv | 90 +++++++++
 4 files changed

// File: rtl/time_uart_pkg.sv
// rtl/time_uart_pkg.sv - shared constants, FSM state type and ASCII helpers for the time UART transmitter
package time_uart_pkg;

    localparam int MSG_LEN        = 7;
    localparam int BITS_PER_FRAME = 10;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    // ST_NEXT is never occupied: the byte hand-off happens in the last STOP cycle.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_NEXT
    } tx_state_t;

    function automatic logic [3:0] tens_of(input logic [5:0] v);
        if (v >= 6'd60)      return 4'd6;
        else if (v >= 6'd50) return 4'd5;
        else if (v >= 6'd40) return 4'd4;
        else if (v >= 6'd30) return 4'd3;
        else if (v >= 6'd20) return 4'd2;
        else if (v >= 6'd10) return 4'd1;
        else                 return 4'd0;
    endfunction

    function automatic logic [3:0] units_of(input logic [5:0] v);
        logic [5:0] t10;
        t10 = {2'b00, tens_of(v)} * 6'd10;
        return 4'(v - t10);
    endfunction

    function automatic logic [7:0] msg_byte(input logic [2:0] idx,
                                            input logic [4:0] h,
                                            input logic [5:0] m);
        case (idx)
            3'd0:    return ASCII_0 + {4'd0, tens_of({1'b0, h})};
            3'd1:    return ASCII_0 + {4'd0, units_of({1'b0, h})};
            3'd2:    return ASCII_COLON;
            3'd3:    return ASCII_0 + {4'd0, tens_of(m)};
            3'd4:    return ASCII_0 + {4'd0, units_of(m)};
            3'd5:    return ASCII_CR;
            default: return ASCII_LF;
        endcase
    endfunction

endpackage

// File: rtl/time_uart_tx_if.sv
// rtl/time_uart_tx_if.sv - time inputs, triggers and UART status of the time transmitter
interface time_uart_tx_if;
    logic [4:0] ore;
    logic [5:0] minute;
    logic       send;
    logic       auto_en;
    logic       tx;
    logic       busy;
    logic       done;

    modport master (output ore, minute, send, auto_en, input tx, busy, done);
    modport slave  (input ore, minute, send, auto_en, output tx, busy, done);
endinterface

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - single-byte 8N1 serialiser, LSB first; accepts the next byte in its last stop cycle
module uart_tx_byte
    import time_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int              BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]      BIT_LAST  = 3'(BITS_PER_FRAME - 3);

    tx_state_t     state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          baud_end;

    assign baud_end = (baud_cnt == BAUD_LAST);
    assign ready    = (state == ST_IDLE) || ((state == ST_STOP) && baud_end);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= ST_IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    if (start) begin
                        shreg <= data;
                        state <= ST_START;
                        tx    <= 1'b0;
                    end
                end
                ST_START: begin
                    baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
                    if (baud_end) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                        tx      <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                    end
                end
                ST_DATA: begin
                    baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
                    if (baud_end) begin
                        if (bit_cnt == BIT_LAST) begin
                            state <= ST_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx      <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end
                end
                ST_STOP: begin
                    baud_cnt <= baud_end ? '0 : baud_cnt + 1'b1;
                    if (baud_end) begin
                        // Back-to-back frames: the next start bit follows the stop bit directly.
                        if (start) begin
                            shreg <= data;
                            state <= ST_START;
                            tx    <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                            tx    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/time_uart_tx.sv
// rtl/time_uart_tx.sv - sends "HH:MM\r\n" over UART on request or on each minute change
module time_uart_tx
    import time_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clock,
    input  logic reset,
    time_uart_tx_if.slave bus
);

    logic [4:0] ore_snap;
    logic [5:0] min_snap;
    logic [5:0] minute_prev;
    logic [2:0] byte_idx;
    logic       busy_r;
    logic       done_r;
    logic       pending;
    logic       trig_auto;
    logic       trig;
    logic       last_byte;
    logic       ser_ready;
    logic       ser_start;
    logic       ser_tx;
    logic [7:0] ser_data;

    assign trig_auto = bus.auto_en && (bus.minute != minute_prev);
    assign trig      = bus.send || trig_auto;
    assign last_byte = (byte_idx == 3'(MSG_LEN - 1));

    // The first byte comes from the live inputs so its start bit begins right after the trigger.
    always_comb begin
        ser_start = 1'b0;
        ser_data  = msg_byte(3'd0, bus.ore, bus.minute);
        if (!busy_r) begin
            ser_start = trig || pending;
        end else begin
            ser_start = ser_ready && !last_byte;
            ser_data  = msg_byte(byte_idx + 3'd1, ore_snap, min_snap);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pending     <= 1'b0;
            byte_idx    <= '0;
            ore_snap    <= '0;
            min_snap    <= '0;
            minute_prev <= bus.minute;
        end else begin
            minute_prev <= bus.minute;
            done_r      <= 1'b0;
            if (!busy_r) begin
                if (trig || pending) begin
                    busy_r   <= 1'b1;
                    pending  <= 1'b0;
                    byte_idx <= '0;
                    ore_snap <= bus.ore;
                    min_snap <= bus.minute;
                end
            end else begin
                if (trig_auto) pending <= 1'b1;
                if (ser_ready) begin
                    if (last_byte) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end else begin
                        byte_idx <= byte_idx + 3'd1;
                    end
                end
            end
        end
    end

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
        .clock (clock),
        .reset (reset),
        .start (ser_start),
        .data  (ser_data),
        .tx    (ser_tx),
        .ready (ser_ready)
    );

    assign bus.tx   = ser_tx;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

endmodule
